// File: rtl/two_of_five_pkg.sv
// Shared definitions for the 2-out-of-5 BCD encoder and its serial transmitter.
// Weights a=7, b=4, c=2, d=1, e=0; digit 0 borrows the otherwise unused 7+4 pair.
package two_of_five_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txState_e;

   localparam int FRAME_BITS = 7;
   localparam int DATA_BITS  = 5;

   localparam logic [4:0] CODE_0 = 5'b11000;
   localparam logic [4:0] CODE_1 = 5'b00011;
   localparam logic [4:0] CODE_2 = 5'b00101;
   localparam logic [4:0] CODE_3 = 5'b00110;
   localparam logic [4:0] CODE_4 = 5'b01001;
   localparam logic [4:0] CODE_5 = 5'b01010;
   localparam logic [4:0] CODE_6 = 5'b01100;
   localparam logic [4:0] CODE_7 = 5'b10001;
   localparam logic [4:0] CODE_8 = 5'b10010;
   localparam logic [4:0] CODE_9 = 5'b10100;

endpackage

// File: rtl/two_of_five_enc.sv
// Purely combinational BCD digit to 2-out-of-5 codeword mapping.
// Also used standalone by the display and validator side, so it carries no state.
module two_of_five_enc
   import two_of_five_pkg::*;
(
   input  logic [3:0] din,
   output logic [4:0] code,
   output logic       invalid
);

   // Non-BCD inputs yield an all-zero code so nothing downstream mistakes them for a digit.
   always_comb begin
      code    = 5'b00000;
      invalid = 1'b0;
      case (din)
         4'd0:    code = CODE_0;
         4'd1:    code = CODE_1;
         4'd2:    code = CODE_2;
         4'd3:    code = CODE_3;
         4'd4:    code = CODE_4;
         4'd5:    code = CODE_5;
         4'd6:    code = CODE_6;
         4'd7:    code = CODE_7;
         4'd8:    code = CODE_8;
         4'd9:    code = CODE_9;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/two_of_five_tx.sv
// Accepts one BCD digit at a time, encodes it 2-out-of-5 and shifts it out as a
// 7-bit frame (start=1, five code bits MSB first, stop=0), each bit BIT_DIV cycles long.
module two_of_five_tx
   import two_of_five_pkg::*;
#(
   parameter int BIT_DIV = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [4:0] code,
   output logic       tx_line,
   output logic       tx_active,
   output logic       err
);

   localparam logic [7:0] LAST_CNT = 8'(BIT_DIV - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   txState_e   state_q,  state_d;
   logic [4:0] code_q,   code_d;
   logic [7:0] divCnt_q, divCnt_d;
   logic [2:0] bitIdx_q, bitIdx_d;
   logic       err_q,    err_d;
   logic       txLine_q, txLine_d;

   logic [4:0] encCode;
   logic       encInvalid;
   logic       bitDone;

   two_of_five_enc encoder (
      .din     (din),
      .code    (encCode),
      .invalid (encInvalid)
   );

   assign bitDone   = (divCnt_q == LAST_CNT);
   assign din_ready = (state_q == IDLE);
   assign tx_active = (state_q != IDLE);
   assign code      = code_q;
   assign tx_line   = txLine_q;
   assign err       = err_q;

   // Next-state logic; tx_line is derived from the next state so the serial output
   // leaves a flop and rises on the cycle right after the handshake.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      divCnt_d = divCnt_q;
      bitIdx_d = bitIdx_q;
      err_d    = 1'b0;
      txLine_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (din_valid) begin
               if (encInvalid) begin
                  err_d = 1'b1;
               end else begin
                  code_d   = encCode;
                  state_d  = START;
                  divCnt_d = 8'd0;
                  bitIdx_d = 3'd0;
               end
            end
         end
         START: begin
            if (bitDone) begin
               divCnt_d = 8'd0;
               bitIdx_d = 3'd0;
               state_d  = DATA;
            end else begin
               divCnt_d = divCnt_q + 8'd1;
            end
         end
         DATA: begin
            if (bitDone) begin
               divCnt_d = 8'd0;
               if (bitIdx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end else begin
               divCnt_d = divCnt_q + 8'd1;
            end
         end
         STOP: begin
            if (bitDone) begin
               divCnt_d = 8'd0;
               state_d  = IDLE;
            end else begin
               divCnt_d = divCnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   txLine_d = 1'b1;
         DATA:    txLine_d = code_d[3'd4 - bitIdx_d];
         default: txLine_d = 1'b0;
      endcase
   end

   // Reset wins over any handshake presented in the same cycle and aborts a frame outright.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         code_q   <= 5'b00000;
         divCnt_q <= 8'd0;
         bitIdx_q <= 3'd0;
         err_q    <= 1'b0;
         txLine_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         divCnt_q <= divCnt_d;
         bitIdx_q <= bitIdx_d;
         err_q    <= err_d;
         txLine_q <= txLine_d;
      end
   end

endmodule
